// File: rtl/exe_if.sv
// ID/EX -> execute -> writeback bundle for the execute stage.
// The master side is the ID/EX register and writeback consumer. The slave side is the execute stage.
interface exe_if #(
  parameter int DSIZE = 32,
  parameter int ISIZE = 32
);
  logic             valid_in;
  logic             alusrc_cntrl_in;
  logic [2:0]       aluop_cntrl_in;
  logic [DSIZE-1:0] rdata1_in;
  logic [DSIZE-1:0] rdata2_in;
  logic [ISIZE-1:0] bit_extval_in;
  logic [4:0]       waddr_in;
  logic [DSIZE-1:0] aluout;
  logic [4:0]       waddr_out;
  logic             wen_out;
  logic             stall_out;

  modport master (
    output valid_in, alusrc_cntrl_in, aluop_cntrl_in, rdata1_in, rdata2_in,
           bit_extval_in, waddr_in,
    input  aluout, waddr_out, wen_out, stall_out
  );

  modport slave (
    input  valid_in, alusrc_cntrl_in, aluop_cntrl_in, rdata1_in, rdata2_in,
           bit_extval_in, waddr_in,
    output aluout, waddr_out, wen_out, stall_out
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU plus a DSIZE-cycle shift-add multiplier.
// While the multiplier runs, the stage stalls the upstream pipeline.
module exe_stage #(
  parameter int DSIZE = 32,
  parameter int ISIZE = 32
) (
  input  logic clk,
  input  logic rst,
  exe_if.slave ex
);
  localparam int CW = $clog2(DSIZE);
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                         OP_OR  = 3'b011, OP_XOR = 3'b100, OP_SLT = 3'b101,
                         OP_SLL = 3'b110, OP_MUL = 3'b111;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [DSIZE-1:0] opb, alu_res, prod_add;
  logic [DSIZE-1:0] aluout_q, aluout_d, prod_q, prod_d;
  logic [DSIZE-1:0] mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       waddr_q, waddr_d;
  logic             wen_q, wen_d;
  logic             is_mul, last;

  if (ISIZE > DSIZE) begin : g_imm_hi
    logic unused_imm_hi;
    assign unused_imm_hi = ^ex.bit_extval_in[ISIZE-1:DSIZE];
  end

  assign opb    = ex.alusrc_cntrl_in ? ex.bit_extval_in[DSIZE-1:0] : ex.rdata2_in;
  assign is_mul = (ex.aluop_cntrl_in == OP_MUL);
  assign last   = (state_q == BUSY) && (cnt_q == CW'(DSIZE-1));

  always_comb begin
    alu_res = '0;
    case (ex.aluop_cntrl_in)
      OP_ADD: alu_res = ex.rdata1_in + opb;
      OP_SUB: alu_res = ex.rdata1_in - opb;
      OP_AND: alu_res = ex.rdata1_in & opb;
      OP_OR:  alu_res = ex.rdata1_in | opb;
      OP_XOR: alu_res = ex.rdata1_in ^ opb;
      OP_SLT: alu_res = {{(DSIZE-1){1'b0}}, ($signed(ex.rdata1_in) < $signed(opb))};
      OP_SLL: alu_res = ex.rdata1_in << opb[4:0];
      default: alu_res = '0;
    endcase
  end

  // Partial-product add for this BUSY step; the final edge writes this sum directly.
  assign prod_add = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    aluout_d = aluout_q;
    waddr_d  = waddr_q;
    wen_d    = 1'b0;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (ex.valid_in) begin
          waddr_d = ex.waddr_in;
          if (is_mul) begin
            mcand_d  = ex.rdata1_in;
            mplier_d = opb;
            prod_d   = '0;
            cnt_d    = '0;
            state_d  = BUSY;
          end else begin
            aluout_d = alu_res;
            wen_d    = |ex.waddr_in;
          end
        end
      end
      BUSY: begin
        prod_d   = prod_add;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last) begin
          aluout_d = prod_add;
          wen_d    = |waddr_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      aluout_q <= '0;
      waddr_q  <= '0;
      wen_q    <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      aluout_q <= aluout_d;
      waddr_q  <= waddr_d;
      wen_q    <= wen_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Stall drops in the last BUSY cycle so ID/EX advances as the product retires.
  assign ex.stall_out = ((state_q == IDLE) && ex.valid_in && is_mul) ||
                        ((state_q == BUSY) && !last);
  assign ex.aluout    = aluout_q;
  assign ex.waddr_out = waddr_q;
  assign ex.wen_out   = wen_q;
endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed vector table, multi-cycle MUL/reset sequences,
// and random traffic against an arithmetic reference model.
module tb_exe_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] exp_alu = '0;
  logic [4:0]  exp_waddr = '0;

  exe_if #(.DSIZE(32), .ISIZE(32)) bus ();
  exe_stage #(.DSIZE(32), .ISIZE(32)) dut (.clk(clk), .rst(rst), .ex(bus.slave));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        alusrc;
    logic [31:0] a, r2, imm;
    logic [4:0]  waddr;
    logic [31:0] exp_alu;
    logic        exp_wen;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    logic [4:0]  sh;
    sh = b[4:0];
    p  = 64'(a) * 64'(b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << sh;
      default: return p[31:0];
    endcase
  endfunction

  task automatic drive(input logic v, input logic src, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] r2, input logic [31:0] imm, input logic [4:0] wa);
    bus.valid_in = v; bus.alusrc_cntrl_in = src; bus.aluop_cntrl_in = op;
    bus.rdata1_in = a; bus.rdata2_in = r2; bus.bit_extval_in = imm; bus.waddr_in = wa;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a single-cycle op (or bubble) and check the next-edge outputs against the model.
  task automatic run_single(input string tag, input logic v, input logic src, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] r2, input logic [31:0] imm,
                            input logic [4:0] wa);
    drive(v, src, op, a, r2, imm, wa);
    #1;
    chk({tag, " stall"}, 32'(bus.stall_out), 32'd0);
    if (v) begin
      exp_alu   = ref_alu(op, a, src ? imm : r2);
      exp_waddr = wa;
    end
    step();
    chk({tag, " aluout"}, bus.aluout, exp_alu);
    chk({tag, " waddr"}, 32'(bus.waddr_out), 32'(exp_waddr));
    chk({tag, " wen"}, 32'(bus.wen_out), 32'(v && wa != 0));
  endtask

  // Issue a MUL and follow it to retirement; stall and wen are checked every cycle.
  task automatic run_mul(input string tag, input logic src, input logic [31:0] a, input logic [31:0] r2,
                         input logic [31:0] imm, input logic [4:0] wa);
    int edges = 0;
    int stall_cycles = 0;
    int early_wen = 0;
    drive(1'b1, src, 3'b111, a, r2, imm, wa);
    #1;
    while (bus.stall_out && edges < 40) begin
      stall_cycles++;
      step();
      edges++;
      if (bus.wen_out) early_wen++;
    end
    step();
    edges++;
    drive(1'b0, 1'b0, 3'b000, '0, '0, '0, '0);
    exp_alu   = ref_alu(3'b111, a, src ? imm : r2);
    exp_waddr = wa;
    chk({tag, " stall cycles"}, 32'(stall_cycles), 32'd32);
    chk({tag, " latency"}, 32'(edges), 32'd33);
    chk({tag, " early wen"}, 32'(early_wen), 32'd0);
    chk({tag, " aluout"}, bus.aluout, exp_alu);
    chk({tag, " waddr"}, 32'(bus.waddr_out), 32'(wa));
    chk({tag, " wen"}, 32'(bus.wen_out), 32'(wa != 0));
  endtask

  vec_t vecs[$];

  initial begin
    int wen_pulses;
    vecs = '{
      '{"add",      3'd0, 1'b0, 32'd5,        32'd7,        32'd0,        5'd3,  32'd12,         1'b1},
      '{"sub imm",  3'd1, 1'b1, 32'd10,       32'd99,       32'hFFFFFFFF, 5'd4,  32'd11,         1'b1},
      '{"slt neg",  3'd5, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        5'd5,  32'd1,          1'b1},
      '{"slt pos",  3'd5, 1'b0, 32'd1,        32'hFFFFFFFF, 32'd0,        5'd5,  32'd0,          1'b1},
      '{"and",      3'd2, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,        5'd6,  32'h00F000F0,   1'b1},
      '{"or",       3'd3, 1'b1, 32'hF0000000, 32'd0,        32'h0000000F, 5'd7,  32'hF000000F,   1'b1},
      '{"xor",      3'd4, 1'b0, 32'hAAAA5555, 32'hFFFF0000, 32'd0,        5'd8,  32'h55555555,   1'b1},
      '{"sll 31",   3'd6, 1'b0, 32'd1,        32'd31,       32'd0,        5'd9,  32'h80000000,   1'b1},
      '{"sll b40",  3'd6, 1'b1, 32'h00000013, 32'd0,        32'h00000023, 5'd10, 32'h00000098,   1'b1},
      '{"add wrap", 3'd0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        5'd11, 32'd0,          1'b1},
      '{"add r0",   3'd0, 1'b0, 32'd20,       32'd22,       32'd0,        5'd0,  32'd42,         1'b0}
    };

    drive(1'b0, 1'b0, 3'b000, '0, '0, '0, '0);
    step();
    step();
    chk("reset aluout", bus.aluout, 32'd0);
    chk("reset waddr", 32'(bus.waddr_out), 32'd0);
    chk("reset wen", 32'(bus.wen_out), 32'd0);
    chk("reset stall", 32'(bus.stall_out), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].alusrc, vecs[i].op, vecs[i].a, vecs[i].r2, vecs[i].imm, vecs[i].waddr);
      #1;
      chk({vecs[i].name, " stall"}, 32'(bus.stall_out), 32'd0);
      step();
      chk({vecs[i].name, " aluout"}, bus.aluout, vecs[i].exp_alu);
      chk({vecs[i].name, " waddr"}, 32'(bus.waddr_out), 32'(vecs[i].waddr));
      chk({vecs[i].name, " wen"}, 32'(bus.wen_out), 32'(vecs[i].exp_wen));
      exp_alu = vecs[i].exp_alu;
      exp_waddr = vecs[i].waddr;
    end

    // A MUL opcode without valid must neither stall nor write.
    run_single("invalid mul", 1'b0, 1'b0, 3'b111, 32'd3, 32'd4, 32'd0, 5'd2);

    run_mul("mul 12345", 1'b0, 32'd12345, 32'hFFFFFFFD, 32'd0, 5'd12);
    chk("mul 12345 value", bus.aluout, 32'hFFFF6F55);
    run_single("add after mul", 1'b1, 1'b0, 3'b000, 32'd1, 32'd1, 32'd0, 5'd13);
    chk("add after mul value", bus.aluout, 32'd2);

    run_mul("mul wrap", 1'b1, 32'h00010000, 32'd0, 32'h00010000, 5'd14);
    run_mul("mul b2b", 1'b0, 32'd7, 32'd6, 32'd0, 5'd15);
    run_mul("mul r0", 1'b0, 32'd9, 32'd9, 32'd0, 5'd0);

    // Reset mid-multiply, at cnt=10 (entry edge plus 10 BUSY edges).
    drive(1'b1, 1'b0, 3'b111, 32'd1234, 32'd5678, 32'd0, 5'd16);
    for (int k = 0; k < 11; k++) step();
    chk("abort pre stall", 32'(bus.stall_out), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort aluout", bus.aluout, 32'd0);
    chk("abort waddr", 32'(bus.waddr_out), 32'd0);
    chk("abort wen", 32'(bus.wen_out), 32'd0);
    chk("abort stall valid mul", 32'(bus.stall_out), 32'd1);
    drive(1'b0, 1'b0, 3'b000, '0, '0, '0, '0);
    #1;
    chk("abort stall idle", 32'(bus.stall_out), 32'd0);
    rst = 1'b0;
    exp_alu = '0;
    exp_waddr = '0;
    run_single("add after abort", 1'b1, 1'b0, 3'b000, 32'd2, 32'd3, 32'd0, 5'd17);
    drive(1'b0, 1'b0, 3'b000, '0, '0, '0, '0);
    wen_pulses = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (bus.wen_out) wen_pulses++;
    end
    chk("abort no spurious wen", 32'(wen_pulses), 32'd0);
    chk("abort aluout held", bus.aluout, 32'd5);

    for (int n = 0; n < 200; n++) begin
      logic        v, src;
      logic [2:0]  op;
      logic [31:0] a, r2, imm;
      logic [4:0]  wa;
      v   = ($urandom_range(0, 3) != 0);
      src = 1'($urandom_range(0, 1));
      op  = 3'($urandom_range(0, 7));
      if (op == 3'b111 && $urandom_range(0, 3) != 0) op = 3'($urandom_range(0, 6));
      a   = $urandom;
      r2  = $urandom;
      imm = $urandom;
      wa  = 5'($urandom_range(0, 31));
      if (v && op == 3'b111) run_mul("rand mul", src, a, r2, imm, wa);
      else run_single("rand", v, src, op, a, r2, imm, wa);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
